// File: rtl/regfile_rename.sv
// Architectural register file with rename state (busy + ROB tag per register).
// Issue looks up both sources against the pre-rename mapping with a commit bypass, then renames rd.
module regfile_rename #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              is_valid,
    input  logic              is_rd_we,
    input  logic [REG_AW-1:0] is_rs1,
    input  logic [REG_AW-1:0] is_rs2,
    input  logic [REG_AW-1:0] is_rd,
    input  logic [TAG_W-1:0]  is_tag,
    input  logic              cm_valid,
    input  logic [REG_AW-1:0] cm_rd,
    input  logic [TAG_W-1:0]  cm_tag,
    input  logic [DATA_W-1:0] cm_data,
    output logic              out_valid,
    output logic              out_rs1_rdy,
    output logic              out_rs2_rdy,
    output logic [DATA_W-1:0] out_rs1_val,
    output logic [DATA_W-1:0] out_rs2_val,
    output logic [TAG_W-1:0]  out_rs1_tag,
    output logic [TAG_W-1:0]  out_rs2_tag,
    output logic [TAG_W-1:0]  out_rd_tag
);

    localparam int NREG = 2 ** REG_AW;

    // Handshake: is_valid is a single-cycle request with no backpressure; the
    // result appears with out_valid one cycle later. en=0 stalls every register,
    // and a flush drops the issue in that cycle.

    logic [DATA_W-1:0] val_q  [NREG];
    logic [TAG_W-1:0]  tag_q  [NREG];
    logic [NREG-1:0]   busy_q;

    logic [REG_AW-1:0] src_addr [2];
    logic              src_rdy  [2];
    logic [DATA_W-1:0] src_val  [2];
    logic [TAG_W-1:0]  src_tag  [2];

    logic issue_go;
    logic rename_go;
    logic commit_go;
    logic commit_clear;

    assign src_addr[0] = is_rs1;
    assign src_addr[1] = is_rs2;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_rdy[s] = 1'b1;
            src_val[s] = '0;
            src_tag[s] = '0;
            if (src_addr[s] == '0) begin
                src_rdy[s] = 1'b1;
            end else if (!busy_q[src_addr[s]]) begin
                src_val[s] = val_q[src_addr[s]];
            end else if (cm_valid && cm_rd == src_addr[s] && cm_tag == tag_q[src_addr[s]]) begin
                // The producer commits this very cycle: forward its data.
                src_val[s] = cm_data;
            end else begin
                src_rdy[s] = 1'b0;
                src_tag[s] = tag_q[src_addr[s]];
            end
        end
    end

    assign issue_go     = is_valid && !flush;
    assign rename_go    = issue_go && is_rd_we && (is_rd != '0);
    assign commit_go    = cm_valid && (cm_rd != '0);
    // A younger rename of the same register in this cycle keeps it busy.
    assign commit_clear = commit_go && busy_q[cm_rd] && (tag_q[cm_rd] == cm_tag)
                          && !(rename_go && is_rd == cm_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q      <= '0;
            out_valid   <= 1'b0;
            out_rs1_rdy <= 1'b0;
            out_rs2_rdy <= 1'b0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rs1_tag <= '0;
            out_rs2_tag <= '0;
            out_rd_tag  <= '0;
        end else if (en) begin
            out_valid <= issue_go;
            if (issue_go) begin
                out_rs1_rdy <= src_rdy[0];
                out_rs2_rdy <= src_rdy[1];
                out_rs1_val <= src_val[0];
                out_rs2_val <= src_val[1];
                out_rs1_tag <= src_tag[0];
                out_rs2_tag <= src_tag[1];
                out_rd_tag  <= is_tag;
            end
            if (flush) begin
                busy_q <= '0;
            end
            if (rename_go) begin
                busy_q[is_rd] <= 1'b1;
                tag_q[is_rd]  <= is_tag;
            end
            if (commit_go) begin
                val_q[cm_rd] <= cm_data;
                if (commit_clear) begin
                    busy_q[cm_rd] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_rename.sv
// Randomised and directed bench for regfile_rename: a reference model pushes the
// expected output state per clock edge, and a monitor pops and compares it.
module tb_regfile_rename;

    typedef struct packed {
        logic        valid;
        logic        rs1_rdy;
        logic        rs2_rdy;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [3:0]  rs1_tag;
        logic [3:0]  rs2_tag;
        logic [3:0]  rd_tag;
    } out_t;

    typedef struct packed {
        logic        rdy;
        logic [31:0] val;
        logic [3:0]  tag;
    } src_t;

    logic        clk = 1'b0;
    logic        rst, en, flush, is_valid, is_rd_we, cm_valid;
    logic [4:0]  is_rs1, is_rs2, is_rd, cm_rd;
    logic [3:0]  is_tag, cm_tag;
    logic [31:0] cm_data;
    logic        out_valid, out_rs1_rdy, out_rs2_rdy;
    logic [31:0] out_rs1_val, out_rs2_val;
    logic [3:0]  out_rs1_tag, out_rs2_tag, out_rd_tag;
    out_t        dut_out;

    int errors = 0;
    int checks = 0;
    out_t exp_q[$];

    logic [31:0] m_val  [32];
    logic [3:0]  m_tag  [32];
    logic        m_busy [32];
    out_t        m_out;

    regfile_rename dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .is_valid(is_valid), .is_rd_we(is_rd_we),
        .is_rs1(is_rs1), .is_rs2(is_rs2), .is_rd(is_rd), .is_tag(is_tag),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
        .out_valid(out_valid), .out_rs1_rdy(out_rs1_rdy), .out_rs2_rdy(out_rs2_rdy),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rs1_tag(out_rs1_tag), .out_rs2_tag(out_rs2_tag), .out_rd_tag(out_rd_tag)
    );

    assign dut_out = '{out_valid, out_rs1_rdy, out_rs2_rdy, out_rs1_val, out_rs2_val,
                       out_rs1_tag, out_rs2_tag, out_rd_tag};

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic src_t look(input logic [4:0] rs);
        src_t r;
        r = '{rdy: 1'b0, val: 32'h0, tag: m_tag[rs]};
        if (rs == 5'd0)                  r = '{1'b1, 32'h0, 4'h0};
        else if (!m_busy[rs])            r = '{1'b1, m_val[rs], 4'h0};
        else if (cm_valid && cm_rd == rs && cm_tag == m_tag[rs])
                                         r = '{1'b1, cm_data, 4'h0};
        return r;
    endfunction

    task automatic model_step();
        src_t s1, s2;
        logic ren, clr;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 32'h0; m_tag[i] = 4'h0; m_busy[i] = 1'b0;
            end
            m_out = '0;
        end else if (en) begin
            s1 = look(is_rs1);
            s2 = look(is_rs2);
            if (is_valid && !flush)
                m_out = '{1'b1, s1.rdy, s2.rdy, s1.val, s2.val, s1.tag, s2.tag, is_tag};
            else
                m_out.valid = 1'b0;
            ren = is_valid && is_rd_we && is_rd != 5'd0 && !flush;
            clr = cm_valid && cm_rd != 5'd0 && m_busy[cm_rd] && m_tag[cm_rd] == cm_tag
                  && !(ren && is_rd == cm_rd);
            if (flush)
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            if (ren) begin
                m_busy[is_rd] = 1'b1;
                m_tag[is_rd]  = is_tag;
            end
            if (cm_valid && cm_rd != 5'd0) begin
                m_val[cm_rd] = cm_data;
                if (clr) m_busy[cm_rd] = 1'b0;
            end
        end
        exp_q.push_back(m_out);
    endtask

    // driver tasks
    task automatic step(input logic iv, input logic we, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [3:0] t, input logic cv,
                        input logic [4:0] crd, input logic [3:0] ct, input logic [31:0] cd);
        is_valid = iv; is_rd_we = we; is_rs1 = r1; is_rs2 = r2; is_rd = rd; is_tag = t;
        cm_valid = cv; cm_rd = crd; cm_tag = ct; cm_data = cd;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 32'h0);
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2);
        step(1'b1, 1'b0, r1, r2, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 32'h0);
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] t);
        step(1'b1, 1'b1, 5'd0, 5'd0, rd, t, 1'b0, 5'd0, 4'd0, 32'h0);
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] t, input logic [31:0] d);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b1, rd, t, d);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        out_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_out !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got v=%b r=%b%b v1=%h v2=%h t=%h/%h/%h, required v=%b r=%b%b v1=%h v2=%h t=%h/%h/%h",
                         $time, dut_out.valid, dut_out.rs1_rdy, dut_out.rs2_rdy, dut_out.rs1_val,
                         dut_out.rs2_val, dut_out.rs1_tag, dut_out.rs2_tag, dut_out.rd_tag,
                         e.valid, e.rs1_rdy, e.rs2_rdy, e.rs1_val, e.rs2_val,
                         e.rs1_tag, e.rs2_tag, e.rd_tag);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        idle();
        idle();
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_rd_tag", {28'h0, out_rd_tag}, 32'h0);
        rst = 1'b0;

        // cold issue: both sources ready with zero
        issue(5'd5, 5'd6);
        chk("cold_valid", {31'h0, out_valid}, 32'h1);
        chk("cold_rdy", {30'h0, out_rs1_rdy, out_rs2_rdy}, 32'h3);
        chk("cold_val1", out_rs1_val, 32'h0);

        // rename, wait on tag, commit, read back
        rename(5'd3, 4'd7);
        issue(5'd3, 5'd0);
        chk("busy_rdy", {31'h0, out_rs1_rdy}, 32'h0);
        chk("busy_tag", {28'h0, out_rs1_tag}, 32'h7);
        commit(5'd3, 4'd7, 32'h1234);
        issue(5'd3, 5'd0);
        chk("commit_val", out_rs1_val, 32'h1234);

        // same-cycle bypass
        rename(5'd3, 4'd7);
        step(1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 4'd0, 1'b1, 5'd3, 4'd7, 32'hABCD);
        chk("bypass_rdy", {31'h0, out_rs1_rdy}, 32'h1);
        chk("bypass_val", out_rs1_val, 32'hABCD);

        // stale-tag commit
        rename(5'd3, 4'd7);
        rename(5'd3, 4'd9);
        commit(5'd3, 4'd7, 32'h11);
        issue(5'd3, 5'd0);
        chk("stale_rdy", {31'h0, out_rs1_rdy}, 32'h0);
        chk("stale_tag", {28'h0, out_rs1_tag}, 32'h9);
        commit(5'd3, 4'd9, 32'h22);
        issue(5'd3, 5'd0);
        chk("fresh_val", out_rs1_val, 32'h22);

        // rs==rd sees the old mapping
        rename(5'd4, 4'd1);
        step(1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 4'd2, 1'b0, 5'd0, 4'd0, 32'h0);
        chk("self_old_tag", {28'h0, out_rs1_tag}, 32'h1);
        chk("self_rd_tag", {28'h0, out_rd_tag}, 32'h2);
        issue(5'd4, 5'd0);
        chk("self_new_tag", {28'h0, out_rs1_tag}, 32'h2);

        // flush keeps committed value; x0 stays zero
        rename(5'd3, 4'd7);
        commit(5'd3, 4'd7, 32'h1234);
        rename(5'd3, 4'd8);
        flush = 1'b1;
        issue(5'd3, 5'd3);
        chk("flush_drops_issue", {31'h0, out_valid}, 32'h0);
        flush = 1'b0;
        issue(5'd3, 5'd0);
        chk("flush_rdy", {31'h0, out_rs1_rdy}, 32'h1);
        chk("flush_val", out_rs1_val, 32'h1234);
        commit(5'd0, 4'd0, 32'h5);
        issue(5'd0, 5'd0);
        chk("x0_val", out_rs1_val, 32'h0);

        // en=0 freezes outputs and drops the presented commit
        issue(5'd3, 5'd0);
        en = 1'b0;
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b1, 5'd3, 4'd0, 32'h77);
        chk("stall_hold", {31'h0, out_valid}, 32'h1);
        en = 1'b1;
        issue(5'd3, 5'd0);
        chk("stall_lost_commit", out_rs1_val, 32'h1234);

        // reset mid-operation discards same-cycle rename and commit
        rst = 1'b1;
        step(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 4'd3, 1'b1, 5'd6, 4'd0, 32'h99);
        rst = 1'b0;
        issue(5'd5, 5'd6);
        chk("midrst_val2", out_rs2_val, 32'h0);

        // randomised traffic on a small register window to force collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] crd;
            logic [3:0] ct;
            rst   = ($urandom_range(199, 0) == 0);
            en    = ($urandom_range(9, 0) != 0);
            flush = ($urandom_range(19, 0) == 0);
            crd   = 5'($urandom_range(7, 0));
            ct    = ($urandom_range(1, 0) != 0) ? m_tag[crd] : 4'($urandom_range(15, 0));
            step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), crd, ct,
                 $urandom);
        end
        rst = 1'b0; en = 1'b1; flush = 1'b0;
        idle();

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
